// File: rtl/commit_trace_buffer.sv
// Compacts up to NCH commits plus one trap/interrupt event per cycle into an in-order trace FIFO.
// Latency: a record written at edge N is at the head right after edge N (first-word fall-through).
// Backpressure: in_ready drops when fewer than NCH+1 entries are free; input presented then is dropped and overflow sticks.
module commit_trace_buffer #(
  parameter int XLEN  = 64,
  parameter int NCH   = 2,
  parameter int DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       commit_valid,
  input  logic [NCH*32-1:0]    commit_inst,
  input  logic [NCH*XLEN-1:0]  commit_pc,
  input  logic [NCH-1:0]       commit_wen,
  input  logic [NCH*5-1:0]     commit_wdest,
  input  logic [NCH*XLEN-1:0]  commit_wdata,
  input  logic                 event_valid,
  input  logic [XLEN-1:0]      event_cause,
  input  logic [XLEN-1:0]      event_pc,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_event,
  output logic [31:0]          out_inst,
  output logic [XLEN-1:0]      out_pc,
  output logic                 out_wen,
  output logic [4:0]           out_wdest,
  output logic [XLEN-1:0]      out_wdata,
  output logic [XLEN-1:0]      out_cause,
  output logic [63:0]          out_seq,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic            is_event;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            wen;
    logic [4:0]      wdest;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] cause;
    logic [63:0]     seq;
  } rec_t;

  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     seq_q, seq_d;
  logic            overflow_q, overflow_d;

  // Slot offsets: pos[i] is the compacted position of channel i, pos[NCH] is the event slot.
  logic [AW-1:0]   pos  [NCH+1];
  logic [AW-1:0]   widx [NCH+1];
  rec_t            wrec [NCH+1];
  logic [NCH:0]    wr_en;
  logic [CW-1:0]   n_wr;
  logic            any_in, enq, deq;
  rec_t            head;

  assign in_ready  = (count_q <= CW'(DEPTH - NCH - 1));
  assign out_valid = (count_q != '0);
  assign any_in    = (|commit_valid) | event_valid;
  assign enq       = any_in & in_ready;
  assign deq       = out_valid & out_ready;
  assign n_wr      = CW'(pos[NCH]) + CW'(event_valid);

  // Build the compacted write records for this cycle: commits in ascending channel order, event last.
  always_comb begin
    pos[0] = '0;
    for (int i = 0; i < NCH; i++) begin
      pos[i+1] = pos[i] + AW'(commit_valid[i]);
    end
    for (int i = 0; i <= NCH; i++) begin
      widx[i]  = wr_ptr_q + pos[i];
      wrec[i]  = '0;
      wr_en[i] = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      wr_en[i]      = enq & commit_valid[i];
      wrec[i].inst  = commit_inst[32*i +: 32];
      wrec[i].pc    = commit_pc[XLEN*i +: XLEN];
      wrec[i].wen   = commit_wen[i];
      wrec[i].wdest = commit_wdest[5*i +: 5];
      wrec[i].wdata = commit_wdata[XLEN*i +: XLEN];
      wrec[i].seq   = seq_q + 64'(pos[i]);
    end
    wr_en[NCH]         = enq & event_valid;
    wrec[NCH].is_event = 1'b1;
    wrec[NCH].pc       = event_pc;
    wrec[NCH].cause    = event_cause;
    wrec[NCH].seq      = seq_q + 64'(pos[NCH]);
  end

  // Next-state for pointers, occupancy, sequence counter and the sticky drop flag.
  always_comb begin
    wr_ptr_d   = enq ? (wr_ptr_q + AW'(n_wr)) : wr_ptr_q;
    rd_ptr_d   = deq ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d    = count_q + (enq ? n_wr : '0) - CW'(deq);
    seq_d      = enq ? (seq_q + 64'(n_wr)) : seq_q;
    overflow_d = overflow_q | (any_in & ~in_ready);
  end

  // Control state registers; reset discards every entry and restarts numbering at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; all slots of one cycle land at distinct consecutive addresses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      for (int i = 0; i <= NCH; i++) begin
        if (wr_en[i]) mem_q[widx[i]] <= wrec[i];
      end
    end
  end

  // Head fields read straight from storage, forced to zero while the FIFO is empty.
  assign head         = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_is_event = head.is_event;
  assign out_inst     = head.inst;
  assign out_pc       = head.pc;
  assign out_wen      = head.wen;
  assign out_wdest    = head.wdest;
  assign out_wdata    = head.wdata;
  assign out_cause    = head.cause;
  assign out_seq      = head.seq;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Testbench for commit_trace_buffer (XLEN=64, NCH=2, DEPTH=16).
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_commit_trace_buffer;

  localparam int XLEN  = 64;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;

  logic                clock;
  logic                reset;
  logic [NCH-1:0]      commit_valid;
  logic [NCH*32-1:0]   commit_inst;
  logic [NCH*XLEN-1:0] commit_pc;
  logic [NCH-1:0]      commit_wen;
  logic [NCH*5-1:0]    commit_wdest;
  logic [NCH*XLEN-1:0] commit_wdata;
  logic                event_valid;
  logic [XLEN-1:0]     event_cause;
  logic [XLEN-1:0]     event_pc;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic                out_is_event;
  logic [31:0]         out_inst;
  logic [XLEN-1:0]     out_pc;
  logic                out_wen;
  logic [4:0]          out_wdest;
  logic [XLEN-1:0]     out_wdata;
  logic [XLEN-1:0]     out_cause;
  logic [63:0]         out_seq;
  logic                overflow;

  commit_trace_buffer #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_inst(commit_inst), .commit_pc(commit_pc),
    .commit_wen(commit_wen), .commit_wdest(commit_wdest), .commit_wdata(commit_wdata),
    .event_valid(event_valid), .event_cause(event_cause), .event_pc(event_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_event(out_is_event), .out_inst(out_inst), .out_pc(out_pc),
    .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata),
    .out_cause(out_cause), .out_seq(out_seq), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_ev;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic [63:0] cause;
    logic [63:0] seq;
  } rec_t;

  rec_t        q[$];
  logic [63:0] m_seq;
  logic        m_ovf;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic clear_inputs();
    commit_valid = '0; commit_inst = '0; commit_pc = '0;
    commit_wen = '0; commit_wdest = '0; commit_wdata = '0;
    event_valid = 1'b0; event_cause = '0; event_pc = '0;
  endtask

  task automatic model_clear();
    q.delete();
    m_seq = '0;
    m_ovf = 1'b0;
  endtask

  // Apply the current inputs to the reference model, then advance one clock.
  task automatic tick();
    rec_t r;
    logic any, rdy;
    any = (|commit_valid) || event_valid;
    rdy = (q.size() <= DEPTH - NCH - 1);
    if (q.size() != 0 && out_ready) r = q.pop_front();
    if (any && rdy) begin
      for (int i = 0; i < NCH; i++) begin
        if (commit_valid[i]) begin
          r.is_ev = 1'b0; r.inst = commit_inst[32*i +: 32]; r.pc = commit_pc[64*i +: 64];
          r.wen = commit_wen[i]; r.wdest = commit_wdest[5*i +: 5]; r.wdata = commit_wdata[64*i +: 64];
          r.cause = '0; r.seq = m_seq; m_seq = m_seq + 64'd1;
          q.push_back(r);
        end
      end
      if (event_valid) begin
        r.is_ev = 1'b1; r.inst = '0; r.pc = event_pc; r.wen = 1'b0; r.wdest = '0;
        r.wdata = '0; r.cause = event_cause; r.seq = m_seq; m_seq = m_seq + 64'd1;
        q.push_back(r);
      end
    end else if (any) begin
      m_ovf = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    out_ready = 1'b0;
    model_clear();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (out_seq !== 64'd0) begin n_bad++; $display("FAIL reset_out_seq got %h want 0", out_seq); end
    n_cmp++;
    if ({out_is_event, out_inst, out_pc, out_wen, out_wdest, out_wdata, out_cause} !== '0) begin
      n_bad++; $display("FAIL reset_out_fields got pc=%h inst=%h cause=%h want all 0", out_pc, out_inst, out_cause);
    end
    reset = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_pair();
    do_reset();
    out_ready = 1'b1;
    commit_valid = 2'b11;
    commit_pc = {64'h1004, 64'h1000};
    commit_inst = {$urandom, $urandom};
    tick();
    clear_inputs();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pair_valid0 got %b want 1", out_valid); end
    n_cmp++; if ({out_seq, out_pc} !== {64'd0, 64'h1000}) begin n_bad++; $display("FAIL pair_rec0 got seq=%0d pc=%h want seq=0 pc=1000", out_seq, out_pc); end
    tick();
    n_cmp++; if ({out_valid, out_seq, out_pc} !== {1'b1, 64'd1, 64'h1004}) begin n_bad++; $display("FAIL pair_rec1 got v=%b seq=%0d pc=%h want v=1 seq=1 pc=1004", out_valid, out_seq, out_pc); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pair_empty got %b want 0", out_valid); end
  endtask

  task automatic test_event();
    do_reset();
    out_ready = 1'b1;
    commit_valid = 2'b10;
    commit_pc = {64'h2000, 64'hdead};
    commit_inst = {32'h00a00093, 32'hffffffff};
    event_valid = 1'b1; event_cause = 64'h8; event_pc = 64'h2004;
    tick();
    clear_inputs();
    n_cmp++;
    if ({out_valid, out_is_event, out_seq, out_pc, out_cause, out_inst} !== {1'b1, 1'b0, 64'd0, 64'h2000, 64'h0, 32'h00a00093}) begin
      n_bad++; $display("FAIL event_commit got v=%b ev=%b seq=%0d pc=%h cause=%h inst=%h want v=1 ev=0 seq=0 pc=2000 cause=0 inst=00a00093",
                        out_valid, out_is_event, out_seq, out_pc, out_cause, out_inst);
    end
    tick();
    n_cmp++;
    if ({out_valid, out_is_event, out_seq, out_pc, out_cause} !== {1'b1, 1'b1, 64'd1, 64'h2004, 64'h8}) begin
      n_bad++; $display("FAIL event_record got v=%b ev=%b seq=%0d pc=%h cause=%h want v=1 ev=1 seq=1 pc=2004 cause=8",
                        out_valid, out_is_event, out_seq, out_pc, out_cause);
    end
    n_cmp++;
    if ({out_inst, out_wen, out_wdest, out_wdata} !== '0) begin
      n_bad++; $display("FAIL event_zero_fields got inst=%h wen=%b wdest=%0d wdata=%h want all 0", out_inst, out_wen, out_wdest, out_wdata);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL event_empty got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready_fill%0d got %b want 1", c, in_ready); end
      commit_valid = 2'b11;
      commit_pc = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready_at14 got %b want 0", in_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_before_drop got %b want 0", overflow); end
    tick();
    clear_inputs();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_after_drop got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      n_cmp++;
      if ({out_valid, out_seq} !== {1'b1, 64'(i)}) begin
        n_bad++; $display("FAIL ovf_drain%0d got v=%b seq=%0d want v=1 seq=%0d", i, out_valid, out_seq, i);
      end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drain_end got %b want 0", out_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  // Continues from the overflowed state left by test_overflow.
  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      commit_valid = 2'b11;
      commit_pc = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    clear_inputs();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_filled got %b want 1", out_valid); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %b want 0", out_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL arst_overflow got %b want 0", overflow); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    model_clear();
    #1;
    reset = 1'b0;
    commit_valid = 2'b01;
    commit_pc = {64'h0, 64'h3000};
    tick();
    clear_inputs();
    n_cmp++;
    if ({out_valid, out_seq, out_pc} !== {1'b1, 64'd0, 64'h3000}) begin
      n_bad++; $display("FAIL arst_next_seq got v=%b seq=%0d pc=%h want v=1 seq=0 pc=3000", out_valid, out_seq, out_pc);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 104; c++) begin
      clear_inputs();
      if (c < 100) begin
        commit_valid = 2'b01;
        commit_pc = {64'h0, 64'(c * 4)};
      end
      tick();
      if (out_valid === 1'b1) begin
        n_cmp++;
        if ({out_seq, out_pc} !== {64'(n), 64'(n * 4)}) begin
          n_bad++; $display("FAIL wrap_rec%0d got seq=%0d pc=%h want seq=%0d pc=%h", n, out_seq, out_pc, n, n * 4);
        end
        n++;
      end
    end
    clear_inputs();
    n_cmp++; if (n != 100) begin n_bad++; $display("FAIL wrap_count got %0d want 100", n); end
  endtask

  task automatic test_random();
    rec_t e;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      n_cmp++;
      if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid cyc%0d got %b want %b", c, out_valid, q.size() != 0); end
      n_cmp++;
      if (in_ready !== (q.size() <= DEPTH - NCH - 1)) begin n_bad++; $display("FAIL rnd_in_ready cyc%0d got %b want %b", c, in_ready, q.size() <= DEPTH - NCH - 1); end
      n_cmp++;
      if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_overflow cyc%0d got %b want %b", c, overflow, m_ovf); end
      if (q.size() != 0) begin
        e = q[0];
        n_cmp++;
        if ({out_is_event, out_inst, out_pc, out_wen, out_wdest, out_wdata, out_cause, out_seq} !==
            {e.is_ev, e.inst, e.pc, e.wen, e.wdest, e.wdata, e.cause, e.seq}) begin
          n_bad++; $display("FAIL rnd_head cyc%0d got ev=%b seq=%0d pc=%h inst=%h cause=%h wd=%h want ev=%b seq=%0d pc=%h inst=%h cause=%h wd=%h",
                            c, out_is_event, out_seq, out_pc, out_inst, out_cause, out_wdata,
                            e.is_ev, e.seq, e.pc, e.inst, e.cause, e.wdata);
        end
      end
      commit_valid = 2'($urandom_range(0, 3));
      commit_inst  = {$urandom, $urandom};
      commit_pc    = {$urandom, $urandom, $urandom, $urandom};
      commit_wen   = 2'($urandom_range(0, 3));
      commit_wdest = 10'($urandom);
      commit_wdata = {$urandom, $urandom, $urandom, $urandom};
      event_valid  = ($urandom_range(0, 7) == 0);
      event_cause  = {$urandom, $urandom};
      event_pc     = {$urandom, $urandom};
      out_ready    = 1'($urandom_range(0, 1));
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_pair();
    test_event();
    test_overflow();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
